// File: rtl/traffic_pkg.sv
// Shared encodings and default durations for the traffic-light interval timer.
package traffic_pkg;

  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;

  localparam logic [1:0] SEL_BASE     = 2'b00;
  localparam logic [1:0] SEL_EXT      = 2'b01;
  localparam logic [1:0] SEL_YEL      = 2'b10;
  localparam logic [1:0] SEL_DEFAULTS = 2'b11;

  localparam int DEF_BASE = 6;
  localparam int DEF_EXT  = 3;
  localparam int DEF_YEL  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/traffic_timer_if.sv
// FSM-to-timer bus. TRAFFIC_TIMER_STATUS_EN adds busy/remaining status signals.
interface traffic_timer_if #(
  parameter int CNT_W = 4
) ();
  logic             start_timer;
  logic [1:0]       interval;
  logic             Prog_Sync;
  logic [1:0]       Time_Sel;
  logic [CNT_W-1:0] Time_Value;
  logic             expired;
`ifdef TRAFFIC_TIMER_STATUS_EN
  logic             busy;
  logic [CNT_W-1:0] remaining;

  modport master (output start_timer, interval, Prog_Sync, Time_Sel, Time_Value,
                  input  expired, busy, remaining);
  modport slave  (input  start_timer, interval, Prog_Sync, Time_Sel, Time_Value,
                  output expired, busy, remaining);
`else
  modport master (output start_timer, interval, Prog_Sync, Time_Sel, Time_Value,
                  input  expired);
  modport slave  (input  start_timer, interval, Prog_Sync, Time_Sel, Time_Value,
                  output expired);
`endif
endinterface

// File: rtl/one_sec_divider.sv
// Prescaler producing a one-cycle tick every CLK_PER_SEC enabled cycles.
module one_sec_divider #(
  parameter int CLK_PER_SEC = 100
) (
  input  logic clk,
  input  logic Reset_N,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int W = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_PER_SEC - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge Reset_N) begin
    if (!Reset_N)        r_cnt <= '0;
    else if (clear)      r_cnt <= '0;
    else if (enable) begin
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + W'(1);
    end
  end

  assign tick = enable && (r_cnt == LAST);

endmodule

// File: rtl/traffic_timer.sv
// Interval timer for the traffic-light FSM: start pulse in, one-cycle expired pulse out.
// Optional status outputs (busy, remaining) under TRAFFIC_TIMER_STATUS_EN.
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int CLK_PER_SEC = 100,
  parameter int CNT_W       = 4,
  parameter int T_BASE_DEF  = DEF_BASE,
  parameter int T_EXT_DEF   = DEF_EXT,
  parameter int T_YEL_DEF   = DEF_YEL
) (
  input  logic clk,
  input  logic Reset_N,
  traffic_timer_if.slave tif
);
  localparam logic [CNT_W-1:0] BASE_D = CNT_W'(T_BASE_DEF);
  localparam logic [CNT_W-1:0] EXT_D  = CNT_W'(T_EXT_DEF);
  localparam logic [CNT_W-1:0] YEL_D  = CNT_W'(T_YEL_DEF);

  logic [CNT_W-1:0] r_base, r_ext, r_yel, r_cnt;
  logic [CNT_W-1:0] w_dur, w_prog_val;
  state_t           r_state;
  logic             r_expired;
  logic             w_tick;

  one_sec_divider #(.CLK_PER_SEC(CLK_PER_SEC)) u_div (
    .clk     (clk),
    .Reset_N (Reset_N),
    .clear   (tif.start_timer),
    .enable  (r_state == RUN),
    .tick    (w_tick)
  );

  // Zero-second durations are clamped to the 1 s minimum at write time.
  assign w_prog_val = (tif.Time_Value == '0) ? CNT_W'(1) : tif.Time_Value;

  always_comb begin
    w_dur = r_base;
    case (tif.interval)
      INT_EXT: w_dur = r_ext;
      INT_YEL: w_dur = r_yel;
      default: w_dur = r_base;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_base <= BASE_D;
      r_ext  <= EXT_D;
      r_yel  <= YEL_D;
    end else if (tif.Prog_Sync) begin
      case (tif.Time_Sel)
        SEL_BASE: r_base <= w_prog_val;
        SEL_EXT:  r_ext  <= w_prog_val;
        SEL_YEL:  r_yel  <= w_prog_val;
        default: begin
          r_base <= BASE_D;
          r_ext  <= EXT_D;
          r_yel  <= YEL_D;
        end
      endcase
    end
  end

  // Start wins over tick/expiry, so a restart on the final tick drops the pulse.
  always_ff @(posedge clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (tif.start_timer) begin
        r_state <= RUN;
        r_cnt   <= w_dur;
      end else if (r_state == RUN && w_tick) begin
        if (r_cnt == CNT_W'(1)) begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          r_expired <= 1'b1;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  assign tif.expired = r_expired;

`ifdef TRAFFIC_TIMER_STATUS_EN
  assign tif.busy      = (r_state == RUN);
  assign tif.remaining = r_cnt;
`endif

endmodule

// File: tb/tb_traffic_timer.sv
// Directed bench for traffic_timer with CLK_PER_SEC=4 (one second = 4 cycles).
module tb_traffic_timer;
  localparam int CPS   = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   c, first, npulse;

  always #5 clk = ~clk;

  traffic_timer_if #(.CNT_W(CNT_W)) tif ();

  traffic_timer #(.CLK_PER_SEC(CPS), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .Reset_N (rst_n),
    .tif     (tif)
  );

  task automatic clr_obs();
    c = 0; first = -1; npulse = 0;
  endtask

  // Advance n cycles, sampling expired 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      c++;
      if (tif.expired === 1'b1) begin
        npulse++;
        if (first < 0) first = c;
      end
    end
  endtask

  task automatic start(input logic [1:0] iv);
    tif.start_timer = 1'b1;
    tif.interval    = iv;
    @(posedge clk); #1;
    tif.start_timer = 1'b0;
    tif.Prog_Sync   = 1'b0;
    checks++;
    assert (tif.expired === 1'b0) else begin
      errors++;
      $error("FAIL start_no_pulse: expired=%b required 0", tif.expired);
    end
    clr_obs();
  endtask

  task automatic prog(input logic [1:0] sel, input logic [CNT_W-1:0] val);
    tif.Prog_Sync  = 1'b1;
    tif.Time_Sel   = sel;
    tif.Time_Value = val;
    tick(1);
    tif.Prog_Sync  = 1'b0;
  endtask

  task automatic chk_pulse(input string tag, input int exp_at);
    checks++;
    assert (first === exp_at) else begin
      errors++;
      $error("FAIL %s_at: pulse cycle %0d required %0d", tag, first, exp_at);
    end
    checks++;
    assert (npulse === 1) else begin
      errors++;
      $error("FAIL %s_cnt: pulses %0d required 1", tag, npulse);
    end
  endtask

  task automatic chk_none(input string tag);
    checks++;
    assert (npulse === 0) else begin
      errors++;
      $error("FAIL %s: pulses %0d required 0", tag, npulse);
    end
  endtask

  initial begin
    tif.start_timer = 1'b0;
    tif.interval    = 2'b00;
    tif.Prog_Sync   = 1'b0;
    tif.Time_Sel    = 2'b00;
    tif.Time_Value  = '0;
    clr_obs();
    #2;
    checks++;
    assert (tif.expired === 1'b0) else begin
      errors++;
      $error("FAIL reset_expired: expired=%b required 0", tif.expired);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(3);
    chk_none("idle_after_reset");

    // Default base: 6 s
    start(2'b00); tick(30); chk_pulse("base_default", 24);

    // Yellow programmed to 5, then defaults restored (2 s)
    prog(2'b10, 4'd5);
    start(2'b10); tick(26); chk_pulse("yel_prog5", 20);
    prog(2'b11, 4'd0);
    start(2'b10); tick(12); chk_pulse("yel_restored", 8);

    // Restart during base count with extended
    start(2'b00); tick(9); chk_none("restart_pre");
    start(2'b01); tick(20); chk_pulse("restart_ext", 12);

    // Zero duration clamps to 1 s
    prog(2'b01, 4'd0);
    start(2'b01); tick(8); chk_pulse("ext_min1", 4);

    // Asynchronous reset mid-count
    start(2'b00); tick(5);
    rst_n = 1'b0; #1;
    checks++;
    assert (tif.expired === 1'b0) else begin
      errors++;
      $error("FAIL midreset_expired: expired=%b required 0", tif.expired);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    clr_obs(); tick(30); chk_none("midreset_no_pulse");
    start(2'b11); tick(30); chk_pulse("int11_base", 24);
    start(2'b01); tick(16); chk_pulse("ext_after_reset", 12);

    // Programming base during a running base count
    start(2'b00); tick(5); prog(2'b00, 4'd9); tick(24);
    chk_pulse("base_prog_running", 24);
    start(2'b00); tick(40); chk_pulse("base_prog9", 36);

    // Program and start on the same edge: start uses old ext value
    tif.Prog_Sync  = 1'b1;
    tif.Time_Sel   = 2'b01;
    tif.Time_Value = 4'd7;
    start(2'b01); tick(16); chk_pulse("prog_same_edge_old", 12);
    start(2'b01); tick(32); chk_pulse("prog_same_edge_new", 28);
    prog(2'b11, 4'd0);

    // Restart exactly on the final tick: no pulse from the first count
    start(2'b01); tick(11); chk_none("final_tick_pre");
    start(2'b01); tick(16); chk_pulse("final_tick_restart", 12);

    // Continuous start holds the timer in restart
    tif.start_timer = 1'b1;
    tif.interval    = 2'b10;
    clr_obs(); tick(30); chk_none("hold_start");
    tif.start_timer = 1'b0;
    clr_obs(); tick(12); chk_pulse("hold_release", 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
